// File: rtl/tcp_stream_tester_if.sv
// Raw TCP stream port between eth_vlg (master side) and the stream tester (slave side).
// Receive side has no back-pressure; transmit side is gated by tx_cts.
interface tcp_stream_if #(
   parameter int DAT_W = 8
) ();
   logic [DAT_W-1:0] rx_dat;
   logic             rx_val;
   logic             tx_cts;
   logic [DAT_W-1:0] tx_dat;
   logic             tx_val;
   logic             tx_snd;

   modport master (
      output rx_dat, rx_val, tx_cts,
      input  tx_dat, tx_val, tx_snd
   );

   modport slave (
      input  rx_dat, rx_val, tx_cts,
      output tx_dat, tx_val, tx_snd
   );
endinterface

// File: rtl/tcp_stream_tester.sv
// TCP traffic engine: buffered echo / pattern generator / pattern checker; TCP_STREAM_TESTER_PRBS_EN selects LFSR patterns.
// Echo latency rx_val->tx_val is 2 cycles minimum; tx only follows a tx_cts=1 cycle, rx has no back-pressure (FIFO overflow drops).
module tcp_stream_tester #(
   parameter int DAT_W          = 8,
   parameter int FIFO_DEPTH     = 10,
   parameter int CNT_W          = 32,
   parameter int SND_IDLE_TICKS = 1000,
   parameter int SEED           = 0
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_connected,
   input  logic [1:0]       i_mode,
   input  logic [CNT_W-1:0] i_gen_len,
   tcp_stream_if.slave      s_tcp,
   output logic             o_busy,
   output logic             o_overflow,
   output logic [CNT_W-1:0] o_rx_cnt,
   output logic [CNT_W-1:0] o_tx_cnt,
   output logic [CNT_W-1:0] o_err_cnt
);
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   localparam int DEPTH  = 1 << FIFO_DEPTH;
   localparam int IDLE_W = $clog2(SND_IDLE_TICKS + 1);
   localparam logic [IDLE_W-1:0] IDLE_RELOAD = IDLE_W'(SND_IDLE_TICKS);
`ifdef TCP_STREAM_TESTER_PRBS_EN
   localparam int PAT_W = 16;
   localparam logic [PAT_W-1:0] PAT_SEED = PAT_W'(SEED) | PAT_W'(1);
`else
   localparam int PAT_W = DAT_W;
   localparam logic [PAT_W-1:0] PAT_SEED = PAT_W'(SEED);
`endif

   state_t              r_state;
   logic [1:0]          r_mode;
   logic                r_conn_d;
   logic [DAT_W-1:0]    r_mem [DEPTH];
   logic [FIFO_DEPTH:0] r_wr_ptr;
   logic [FIFO_DEPTH:0] r_rd_ptr;
   logic [PAT_W-1:0]    r_pat;
   logic [DAT_W-1:0]    r_tx_dat;
   logic                r_tx_val;
   logic                r_tx_snd;
   logic                r_busy;
   logic                r_overflow;
   logic [CNT_W-1:0]    r_rx_cnt;
   logic [CNT_W-1:0]    r_tx_cnt;
   logic [CNT_W-1:0]    r_err_cnt;
   logic [IDLE_W-1:0]   r_idle_cnt;
   logic                r_snd_pend;

   logic             w_connect_rise;
   logic             w_run;
   logic             w_echo;
   logic             w_gen;
   logic             w_chk;
   logic             w_empty;
   logic             w_full;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;
   logic             w_gen_done;
   logic             w_gen_fire;
   logic             w_mismatch;
   logic [DAT_W-1:0] w_pat_sym;
   logic [PAT_W-1:0] w_pat_next;

   assign w_connect_rise = i_connected & ~r_conn_d;
   assign w_run  = (r_state == ST_RUN) & i_connected;
   assign w_echo = (r_mode == 2'd0) | (r_mode == 2'd3);
   assign w_gen  = (r_mode == 2'd1);
   assign w_chk  = (r_mode == 2'd2);

   // Extra pointer MSB tells a full FIFO from an empty one when the index bits match.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[FIFO_DEPTH] != r_rd_ptr[FIFO_DEPTH]) &&
                    (r_wr_ptr[FIFO_DEPTH-1:0] == r_rd_ptr[FIFO_DEPTH-1:0]);
   assign w_pop   = w_run & w_echo & s_tcp.tx_cts & ~w_empty;
   assign w_push  = w_run & w_echo & s_tcp.rx_val & (~w_full | w_pop);
   assign w_drop  = w_run & w_echo & s_tcp.rx_val & w_full & ~w_pop;

   assign w_gen_done = (i_gen_len != '0) && (r_tx_cnt == i_gen_len);
   assign w_gen_fire = w_run & w_gen & s_tcp.tx_cts & ~w_gen_done;

   assign w_pat_sym  = r_pat[DAT_W-1:0];
   assign w_mismatch = (s_tcp.rx_dat != w_pat_sym);
`ifdef TCP_STREAM_TESTER_PRBS_EN
   assign w_pat_next = {r_pat[14:0], r_pat[15] ^ r_pat[13] ^ r_pat[12] ^ r_pat[10]};
`else
   assign w_pat_next = r_pat + PAT_W'(1);
`endif

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr[FIFO_DEPTH-1:0]] <= s_tcp.rx_dat;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state    <= ST_IDLE;
         r_mode     <= 2'd0;
         r_conn_d   <= 1'b0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_pat      <= PAT_SEED;
         r_tx_dat   <= '0;
         r_tx_val   <= 1'b0;
         r_tx_snd   <= 1'b0;
         r_busy     <= 1'b0;
         r_overflow <= 1'b0;
         r_rx_cnt   <= '0;
         r_tx_cnt   <= '0;
         r_err_cnt  <= '0;
         r_idle_cnt <= '0;
         r_snd_pend <= 1'b0;
      end else begin
         r_conn_d <= i_connected;
         r_tx_val <= 1'b0;
         r_tx_snd <= 1'b0;
         if (!i_connected) begin
            // Counters and overflow hold so software can read them after the link drops.
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_idle_cnt <= '0;
            r_snd_pend <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_connect_rise) begin
                     r_state    <= ST_RUN;
                     r_busy     <= 1'b1;
                     r_mode     <= i_mode;
                     r_pat      <= PAT_SEED;
                     r_overflow <= 1'b0;
                     r_rx_cnt   <= '0;
                     r_tx_cnt   <= '0;
                     r_err_cnt  <= '0;
                     r_wr_ptr   <= '0;
                     r_rd_ptr   <= '0;
                     r_idle_cnt <= '0;
                     r_snd_pend <= 1'b0;
                  end
               end
               ST_RUN: begin
                  if (w_gen && w_gen_done) begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                  end
                  if (s_tcp.rx_val) r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                  if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                  if (w_drop) r_overflow <= 1'b1;
                  if (w_pop) begin
                     r_rd_ptr <= r_rd_ptr + 1'b1;
                     r_tx_val <= 1'b1;
                     r_tx_dat <= r_mem[r_rd_ptr[FIFO_DEPTH-1:0]];
                     r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                  end
                  if (w_gen_fire) begin
                     r_tx_val <= 1'b1;
                     r_tx_dat <= w_pat_sym;
                     r_pat    <= w_pat_next;
                     r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                  end
                  if (w_chk && s_tcp.rx_val) begin
                     if (w_mismatch && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + CNT_W'(1);
`ifdef TCP_STREAM_TESTER_PRBS_EN
                     r_pat <= w_pat_next;
`else
                     r_pat <= w_mismatch ? (s_tcp.rx_dat + DAT_W'(1)) : w_pat_next;
`endif
                  end
               end
               default: ;
            endcase

            // Flush timer: tx_snd fires after SND_IDLE_TICKS quiet cycles following a symbol.
            if (r_state != ST_IDLE) begin
               if (r_tx_val) begin
                  r_idle_cnt <= IDLE_RELOAD;
                  r_snd_pend <= 1'b1;
               end else if (r_snd_pend) begin
                  if (r_idle_cnt <= IDLE_W'(1)) begin
                     r_tx_snd   <= 1'b1;
                     r_snd_pend <= 1'b0;
                     r_idle_cnt <= '0;
                  end else begin
                     r_idle_cnt <= r_idle_cnt - IDLE_W'(1);
                  end
               end
            end
         end
      end
   end

   assign s_tcp.tx_dat = r_tx_dat;
   assign s_tcp.tx_val = r_tx_val;
   assign s_tcp.tx_snd = r_tx_snd;
   assign o_busy       = r_busy;
   assign o_overflow   = r_overflow;
   assign o_rx_cnt     = r_rx_cnt;
   assign o_tx_cnt     = r_tx_cnt;
   assign o_err_cnt    = r_err_cnt;
endmodule

// File: tb/tb_tcp_stream_tester.sv
// Scoreboard bench for tcp_stream_tester: stimulus queues expected tx bytes, a negedge monitor pops and compares.
module tb_tcp_stream_tester;
   localparam int DAT_W = 8;
   localparam int CNT_W = 32;
   localparam int SND_T = 20;

   logic             clk;
   logic             rst_n;
   logic             connected;
   logic [1:0]       mode;
   logic [CNT_W-1:0] gen_len;
   logic             busy;
   logic             overflow;
   logic [CNT_W-1:0] rx_cnt;
   logic [CNT_W-1:0] tx_cnt;
   logic [CNT_W-1:0] err_cnt;

   tcp_stream_if #(.DAT_W(DAT_W)) tcp ();

   tcp_stream_tester #(
      .DAT_W(DAT_W), .FIFO_DEPTH(4), .CNT_W(CNT_W),
      .SND_IDLE_TICKS(SND_T), .SEED(16)
   ) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_connected(connected), .i_mode(mode),
      .i_gen_len(gen_len), .s_tcp(tcp), .o_busy(busy), .o_overflow(overflow),
      .o_rx_cnt(rx_cnt), .o_tx_cnt(tx_cnt), .o_err_cnt(err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   logic [DAT_W-1:0] exp_q [$];
   int first_tx = -1;
   int last_tx  = -1;
   int snd_cnt  = 0;
   int snd_cyc  = -1;
   logic prev_cts = 1'b0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (tcp.tx_val) begin
            chk("tx_after_cts_low", {31'd0, prev_cts}, 32'd1);
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_tx: got 0x%0h, expected no symbol", tcp.tx_dat);
            end else begin
               chk("tx_dat", {24'd0, tcp.tx_dat}, {24'd0, exp_q.pop_front()});
            end
            if (first_tx < 0) first_tx = cyc;
            last_tx = cyc;
         end
         if (tcp.tx_snd) begin
            snd_cnt++;
            snd_cyc = cyc;
         end
      end
      prev_cts = tcp.tx_cts;
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic connect(input logic [1:0] m);
      connected = 1'b0;
      tick();
      mode = m;
      connected = 1'b1;
      tick();
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      chk(name, exp_q.size(), 0);
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      connected = 1'b0;
      mode = 2'd0;
      gen_len = '0;
      tcp.rx_dat = '0;
      tcp.rx_val = 1'b0;
      tcp.tx_cts = 1'b0;
      tick(2);

      // Reset state
      chk("rst_tx_val", {31'd0, tcp.tx_val}, 0);
      chk("rst_tx_snd", {31'd0, tcp.tx_snd}, 0);
      chk("rst_tx_dat", {24'd0, tcp.tx_dat}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_overflow", {31'd0, overflow}, 0);
      chk("rst_counts", rx_cnt | tx_cnt | err_cnt, 0);
      rst_n = 1'b1;
      tick(2);
      chk("idle_without_connect", {31'd0, busy}, 0);

      // Echo, no stall: 0x00..0xFF
      tcp.tx_cts = 1'b1;
      connect(2'd0);
      chk("echo_busy", {31'd0, busy}, 1);
      first_tx = -1;
      n = 0;
      for (int i = 0; i < 256; i++) begin
         exp_q.push_back(DAT_W'(i));
         tcp.rx_val = 1'b1;
         tcp.rx_dat = DAT_W'(i);
         if (i == 0) n = cyc;
         tick();
      end
      tcp.rx_val = 1'b0;
      wait_drain("echo_drain", 20);
      chk("echo_latency", first_tx - n, 2);
      chk("echo_rx_cnt", rx_cnt, 256);
      chk("echo_tx_cnt", tx_cnt, 256);
      chk("echo_overflow", {31'd0, overflow}, 0);

      // Echo overflow: 16-entry FIFO, 20 pushes while stalled
      tcp.tx_cts = 1'b0;
      connect(2'd0);
      chk("ovf_cleared_rx_cnt", rx_cnt, 0);
      for (int i = 0; i < 20; i++) begin
         if (i < 16) exp_q.push_back(DAT_W'(8'hA0 + i));
         tcp.rx_val = 1'b1;
         tcp.rx_dat = DAT_W'(8'hA0 + i);
         tick();
      end
      tcp.rx_val = 1'b0;
      tick();
      chk("ovf_flag", {31'd0, overflow}, 1);
      chk("ovf_no_tx_while_stalled", tx_cnt, 0);
      tcp.tx_cts = 1'b1;
      wait_drain("ovf_drain", 40);
      tick(5);
      chk("ovf_tx_cnt", tx_cnt, 16);
      chk("ovf_rx_cnt", rx_cnt, 20);

      // Disconnect mid-echo with buffered data
      tcp.tx_cts = 1'b0;
      connect(2'd0);
      for (int i = 0; i < 50; i++) begin
         tcp.rx_val = 1'b1;
         tcp.rx_dat = DAT_W'(8'h55 + i);
         tick();
      end
      tcp.rx_val = 1'b0;
      connected = 1'b0;
      tcp.tx_cts = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("disc_tx_val", {31'd0, tcp.tx_val}, 0);
      chk("disc_busy", {31'd0, busy}, 0);
      chk("disc_rx_cnt_hold", rx_cnt, 50);
      tick(5);
      mode = 2'd0;
      connected = 1'b1;
      tick();
      chk("reconn_rx_cnt", rx_cnt, 0);
      chk("reconn_overflow", {31'd0, overflow}, 0);
      tick(10);
      chk("reconn_no_stale", tx_cnt, 0);

      // Generate: SEED=0x10, 300 symbols, tx_cts toggling
      for (int i = 0; i < 300; i++) exp_q.push_back(DAT_W'(16 + i));
      gen_len = 300;
      tcp.tx_cts = 1'b0;
      connect(2'd1);
      snd_cnt = 0;
      n = 0;
      while (busy && n < 2000) begin
         tcp.tx_cts = ~tcp.tx_cts;
         tick();
         n++;
      end
      chk("gen_finished_in_budget", {31'd0, busy}, 0);
      tcp.tx_cts = 1'b1;
      tick(SND_T + 20);
      chk("gen_drain", exp_q.size(), 0);
      chk("gen_tx_cnt", tx_cnt, 300);
      chk("gen_done_not_busy", {31'd0, busy}, 0);
      chk("gen_snd_pulses", snd_cnt, 1);
      chk("gen_snd_delay", snd_cyc - last_tx, SND_T + 1);

      // Check mode: expected starts at SEED=0x10; one bad symbol at 0x17
      connect(2'd2);
      begin
         logic [7:0] vec [6];
         vec = '{8'h10, 8'h11, 8'h12, 8'h17, 8'h18, 8'h19};
         for (int i = 0; i < 6; i++) begin
            tcp.rx_val = 1'b1;
            tcp.rx_dat = vec[i];
            tick();
         end
      end
      tcp.rx_val = 1'b0;
      tick();
      chk("chk_err_cnt", err_cnt, 1);
      chk("chk_rx_cnt", rx_cnt, 6);
      for (int i = 0; i < 100; i++) begin
         tcp.rx_val = 1'b1;
         tcp.rx_dat = DAT_W'(8'h1A + i);
         tick();
      end
      tcp.rx_val = 1'b0;
      tick();
      chk("chk_err_after_good", err_cnt, 1);
      chk("chk_rx_cnt_106", rx_cnt, 106);
      chk("chk_no_tx", tx_cnt, 0);

      // Async reset mid-generation
      for (int i = 0; i < 100; i++) exp_q.push_back(DAT_W'(16 + i));
      gen_len = 0;
      tcp.tx_cts = 1'b1;
      connect(2'd1);
      tick(20);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_tx_val", {31'd0, tcp.tx_val}, 0);
      chk("arst_tx_cnt", tx_cnt, 0);
      chk("arst_busy", {31'd0, busy}, 0);
      chk("arst_tx_dat", {24'd0, tcp.tx_dat}, 0);
      exp_q.delete();
      connected = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(5);
      chk("arst_idle_busy", {31'd0, busy}, 0);
      chk("arst_idle_tx_cnt", tx_cnt, 0);
      gen_len = 3;
      for (int i = 0; i < 3; i++) exp_q.push_back(DAT_W'(16 + i));
      connect(2'd1);
      wait_drain("arst_regen_drain", 20);
      tick(3);
      chk("arst_regen_tx_cnt", tx_cnt, 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/tcp_stream_tester.md
Name: tcp_stream_tester

Overview:
- Parametrised traffic engine between the raw TCP port of eth_vlg and user logic.
- Supersedes the one-register echo loop in the top level. That loop drops bytes whenever tcp_cts falls; this block buffers them.
- Three runtime modes: buffered echo, pattern generator, pattern checker.
- Provides byte and error counters for link and throughput tests.

Parameters:
- DAT_W, 8, data lane width in bits (stream symbol width).
- FIFO_DEPTH, 10, log2 of echo FIFO entries.
- CNT_W, 32, width of the byte and error counters.
- SND_IDLE_TICKS, 1000, idle cycles after the last tx symbol before tx_snd pulses.
- SEED, 0, first value of the generated and expected pattern.

Ports:
- clk  in  1  stack clock (125 MHz)
- reset_n  in  1  asynchronous active-low reset
- connected  in  1  TCP connection up (from eth_vlg)
- mode  in  2  0=echo, 1=generate, 2=check, 3=reserved (acts as echo); latched on rising edge of connected
- gen_len  in  CNT_W  symbols to generate; 0=unbounded
- rx_dat  in  DAT_W  stack receive data (tcp_dout)
- rx_val  in  1  stack receive valid (tcp_vout); no back-pressure
- tx_cts  in  1  stack clear-to-send (tcp_cts)
- tx_dat  out  DAT_W  transmit data (tcp_din)
- tx_val  out  1  transmit valid (tcp_vin)
- tx_snd  out  1  force-send pulse (tcp_snd)
- busy  out  1  state is RUN
- overflow  out  1  sticky: echo symbol dropped
- rx_cnt  out  CNT_W  symbols received
- tx_cnt  out  CNT_W  symbols sent
- err_cnt  out  CNT_W  checker mismatches, saturating

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO empty; pattern registers = SEED.
- Clock and reset: single clock clk; reset_n is asynchronous and active-low.
- FSM states:
  - IDLE: on connected 0->1, latch mode, clear all counters and overflow, load SEED, go to RUN.
  - RUN: from generate mode, go to DONE when tx_cnt reaches gen_len (gen_len != 0).
  - DONE: hold counters; tx_val stays 0.
  - Any state: connected=0 forces IDLE next cycle. FIFO is flushed, tx_val=0, tx_snd=0, counters hold their values until the next connect.
- rx_cnt: increments on every rx_val while in RUN, in all modes. tx_cnt increments on every tx_val cycle.
- Echo mode:
  - rx symbol is pushed to the FIFO when rx_val=1.
  - Pop occurs when tx_cts=1 and FIFO is not empty.
  - tx_dat and tx_val are registered from the pop, giving 2 cycles minimum from rx_val to tx_val.
  - Push while full with no pop in the same cycle: symbol dropped, overflow set.
  - Push and pop in the same cycle while full: push accepted.
  - Pointers wrap modulo 2^FIFO_DEPTH. Full/empty are distinguished by an extra pointer bit.
- Generate mode:
  - Each cycle with tx_cts=1 in RUN: tx_val=1 on the next cycle, tx_dat = pattern, then pattern <= pattern+1 (mod 2^DAT_W).
  - Exactly gen_len symbols are emitted. tx_cts low gaps insert no symbols.
  - rx data is counted but ignored.
- Check mode:
  - Each rx_val: compare rx_dat with the expected value.
  - Mismatch: err_cnt+1 (saturates at all-ones) and expected <= rx_dat+1 (resync). Match: expected+1.
  - tx_val stays 0.
- tx_snd:
  - An idle counter reloads on each tx_val and decrements otherwise.
  - On reaching 0 after at least one tx since the last pulse: one-cycle tx_snd pulse, then the counter stops until the next tx_val.
  - Never pulses in IDLE.
- tx_val is never asserted in a cycle following tx_cts=0.

Optional Feature:
- Macro: TCP_STREAM_TESTER_PRBS_EN.
- Defined: the generator and the checker's expected value use a 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, seeded with SEED|1. The LFSR advances one step per symbol; symbol = low DAT_W bits. The checker does not resync on mismatch; expected always advances.
- Undefined: incrementing pattern as described above; no LFSR logic is synthesised.

Test Plan:
- Echo no stall: connect with mode=0, send 0x00..0xFF with tx_cts=1 -> same 256 bytes in order, first tx_val 2 cycles after first rx_val, rx_cnt=tx_cnt=256, overflow=0.
- Echo overflow: FIFO_DEPTH=4, tx_cts=0, push 20 bytes -> first 16 held, overflow=1. Raise tx_cts -> exactly those 16 bytes emitted.
- Generate: SEED=0x10, gen_len=300, tx_cts toggling 1/0 -> 300 symbols 0x10..0x3B wrapping through 0xFF, state DONE, tx_cnt=300, one tx_snd pulse SND_IDLE_TICKS after the last symbol.
- Check: SEED=0, feed 0,1,2,7,8,9 -> err_cnt=1 (at 7), rx_cnt=6. Then feed 100 correct bytes -> err_cnt stays 1.
- Disconnect mid-echo: 50 bytes buffered with tx_cts=0, drop connected -> tx_val=0 from the next cycle, FIFO empty. Reconnect -> counters cleared, no stale data emitted.
- Async reset: assert reset_n=0 mid-generation between clock edges -> all outputs 0 immediately. After release, state IDLE until the next connected rising edge.
